// File: rtl/dlx_store_pack_if.sv
// Store-side bus between the DLX pipeline, the store unit and data memory.
// The slave modport is the store unit's view; the master modport is the pipeline/memory view.
interface dlx_store_pack_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  st_valid;
   logic                  st_ready;
   logic [ADDR_WIDTH-1:0] st_addr;
   logic [DATA_WIDTH-1:0] st_data;
   logic [1:0]            st_size;
   logic                  stall;
   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [3:0]            mem_be;
   logic                  mem_ack;
   logic                  st_err;
   logic [ADDR_WIDTH-1:0] st_err_addr;

   modport slave (
      input  st_valid, st_addr, st_data, st_size, mem_ack,
      output st_ready, stall, mem_req, mem_addr, mem_wdata, mem_be, st_err, st_err_addr
   );

   modport master (
      output st_valid, st_addr, st_data, st_size, mem_ack,
      input  st_ready, stall, mem_req, mem_addr, mem_wdata, mem_be, st_err, st_err_addr
   );
endinterface

// File: rtl/dlx_store_pack.sv
// DLX memory-stage store unit: big-endian lane packing, byte enables and a
// req/ack write handshake; misaligned or illegal stores are rejected with st_err.
module dlx_store_pack #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input logic             clk,
   input logic             rst_n,
   dlx_store_pack_if.slave bus
);
   typedef enum logic {IDLE, WRITE} state_t;

   state_t                state_q, state_d;
   logic                  mem_req_q, mem_req_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]            mem_be_q, mem_be_d;
   logic                  st_err_q, st_err_d;
   logic [ADDR_WIDTH-1:0] st_err_addr_q, st_err_addr_d;

   logic [1:0]            offset;
   logic [DATA_WIDTH-1:0] pack_wdata;
   logic [3:0]            pack_be;
   logic                  pack_legal;

   assign offset = bus.st_addr[1:0];

   // Lane 0 is the most significant byte, so byte enables walk down as the offset grows.
   always_comb begin
      pack_wdata = bus.st_data;
      pack_be    = 4'b0000;
      pack_legal = 1'b0;
      case (bus.st_size)
         2'b00: begin
            pack_wdata = {4{bus.st_data[7:0]}};
            pack_be    = 4'b1000 >> offset;
            pack_legal = 1'b1;
         end
         2'b01: begin
            pack_wdata = {2{bus.st_data[15:0]}};
            pack_be    = offset[1] ? 4'b0011 : 4'b1100;
            pack_legal = ~offset[0];
         end
         2'b10: begin
            pack_wdata = bus.st_data;
            pack_be    = 4'b1111;
            pack_legal = (offset == 2'b00);
         end
         default: begin
            pack_wdata = bus.st_data;
            pack_be    = 4'b0000;
            pack_legal = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d       = state_q;
      mem_req_d     = mem_req_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_be_d      = mem_be_q;
      st_err_d      = 1'b0;
      st_err_addr_d = st_err_addr_q;
      case (state_q)
         IDLE: begin
            if (bus.st_valid) begin
               mem_addr_d  = {bus.st_addr[ADDR_WIDTH-1:2], 2'b00};
               mem_wdata_d = pack_wdata;
               if (pack_legal) begin
                  mem_be_d  = pack_be;
                  mem_req_d = 1'b1;
                  state_d   = WRITE;
               end else begin
                  mem_be_d      = 4'b0000;
                  st_err_d      = 1'b1;
                  st_err_addr_d = bus.st_addr;
               end
            end
         end
         WRITE: begin
            if (bus.mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_be_q      <= 4'b0000;
         st_err_q      <= 1'b0;
         st_err_addr_q <= '0;
      end else begin
         state_q       <= state_d;
         mem_req_q     <= mem_req_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_be_q      <= mem_be_d;
         st_err_q      <= st_err_d;
         st_err_addr_q <= st_err_addr_d;
      end
   end

   assign bus.st_ready    = (state_q == IDLE);
   assign bus.stall       = bus.st_valid & (state_q != IDLE);
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.mem_be      = mem_be_q;
   assign bus.st_err      = st_err_q;
   assign bus.st_err_addr = st_err_addr_q;
endmodule
